pirdsp_simd_alu_pipe: RTL and testbench

PIRDSP_SIMD_ALU_PIPE -- requirements
Module: pirdsp_simd_alu_pipe

---
 rtl/pirdsp_simd_alu_pipe.sv | 140 ++++++++++++++
 tb/tb_pirdsp_simd_alu_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pirdsp_simd_alu_pipe.sv
// rtl/pirdsp_simd_alu_pipe.sv - two-stage SIMD three-input ALU with lane-split accumulator
//
// Purpose: each accepted beat is registered in stage 1. The lane-parallel
// W+X+Y (+Z) arithmetic or logical result is then computed combinationally
// and registered in stage 2, which presents S/cout. An internal accumulator
// can stand in for W. It is updated at the same moment a result enters
// stage 2, so a back-to-back accumulating beat sitting in stage 1 always
// sees the freshly written value.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_valid / in_ready     operand beat handshake (in_ready = advance)
//   W, X, Y, Z [WIDTH]      operands
//   op [2]                  00 sum, 01 xor3, 10 and, 11 or
//   z_inv, wxy_inv, s_inv   invert Z, the W+X+Y partial, the result
//   cin [LANES]             per-lane carry-in of the W+X+Y adder
//   acc_en, acc_clr         use ACC in place of W / read ACC as zero
//   out_valid / out_ready   result handshake
//   S [WIDTH], cout [LANES] result and per-lane carry-out

module pirdsp_simd_alu_pipe #(
    parameter int WIDTH = 48,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] W,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] Z,
    input  logic [1:0]       op,
    input  logic             z_inv,
    input  logic             wxy_inv,
    input  logic             s_inv,
    input  logic [LANES-1:0] cin,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic [LANES-1:0] cout
);

    localparam int LW = WIDTH / LANES;

    // Stage-1 registers
    logic             s1_valid;
    logic [WIDTH-1:0] s1_w, s1_x, s1_y, s1_z;
    logic [1:0]       s1_op;
    logic             s1_z_inv, s1_wxy_inv, s1_s_inv;
    logic [LANES-1:0] s1_cin;
    logic             s1_acc_en, s1_acc_clr;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] res_s;
    logic [LANES-1:0] res_c;
    logic             advance;

    // The whole pipe moves together; nothing moves while a result is held.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < LANES; k++) begin : gen_lane
        logic [LW-1:0] lane_w, lane_x, lane_y, lane_zs;
        logic [LW-1:0] lane_t, lane_t2, lane_sum, lane_sel;
        logic          lane_c;

        assign lane_x  = s1_x[k*LW +: LW];
        assign lane_y  = s1_y[k*LW +: LW];
        assign lane_w  = s1_acc_clr ? '0 : (s1_acc_en ? acc[k*LW +: LW] : s1_w[k*LW +: LW]);
        assign lane_zs = s1_z[k*LW +: LW] ^ {LW{s1_z_inv}};

        // Carries stop at the lane boundary: every sum is truncated to LW bits.
        assign lane_t  = lane_w + lane_x + lane_y + LW'(s1_cin[k]);
        assign lane_t2 = lane_t ^ {LW{s1_wxy_inv}};

        // The extra z_inv carry-in turns ~Z into -Z (two's complement).
        assign {lane_c, lane_sum} = {1'b0, lane_t2} + {1'b0, lane_zs} + (LW+1)'(s1_z_inv);

        always_comb begin
            lane_sel = lane_sum;
            case (s1_op)
                2'b00:   lane_sel = lane_sum;
                2'b01:   lane_sel = lane_x ^ lane_zs ^ lane_y;
                2'b10:   lane_sel = lane_x & lane_zs;
                default: lane_sel = lane_x | lane_zs;
            endcase
        end

        assign res_s[k*LW +: LW] = lane_sel ^ {LW{s1_s_inv}};
        assign res_c[k]          = (s1_op == 2'b00) ? lane_c : 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid   <= 1'b0;
            s1_w       <= '0;
            s1_x       <= '0;
            s1_y       <= '0;
            s1_z       <= '0;
            s1_op      <= '0;
            s1_z_inv   <= 1'b0;
            s1_wxy_inv <= 1'b0;
            s1_s_inv   <= 1'b0;
            s1_cin     <= '0;
            s1_acc_en  <= 1'b0;
            s1_acc_clr <= 1'b0;
            out_valid  <= 1'b0;
            S          <= '0;
            cout       <= '0;
            acc        <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_w       <= W;
                s1_x       <= X;
                s1_y       <= Y;
                s1_z       <= Z;
                s1_op      <= op;
                s1_z_inv   <= z_inv;
                s1_wxy_inv <= wxy_inv;
                s1_s_inv   <= s_inv;
                s1_cin     <= cin;
                s1_acc_en  <= acc_en;
                s1_acc_clr <= acc_clr;
            end
            out_valid <= s1_valid;
            S         <= res_s;
            cout      <= res_c;
            // ACC updates in the same edge the result enters stage 2, so the
            // next beat already in stage 1 reads it without forwarding.
            if (s1_valid && (s1_acc_en || s1_acc_clr)) begin
                acc <= res_s;
            end
        end
    end

endmodule

// File: tb/tb_pirdsp_simd_alu_pipe.sv
// tb/tb_pirdsp_simd_alu_pipe.sv - scoreboard bench for pirdsp_simd_alu_pipe

module tb_pirdsp_simd_alu_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [47:0] W, X, Y, Z;
    logic [1:0]  op;
    logic        z_inv, wxy_inv, s_inv;
    logic [3:0]  cin;
    logic        acc_en, acc_clr;
    logic        out_valid, out_ready;
    logic [47:0] S;
    logic [3:0]  cout;

    pirdsp_simd_alu_pipe #(.WIDTH(48), .LANES(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .W(W), .X(X), .Y(Y), .Z(Z), .op(op), .z_inv(z_inv), .wxy_inv(wxy_inv),
        .s_inv(s_inv), .cin(cin), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .S(S), .cout(cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] s;
        logic [3:0]  c;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [47:0] outs[$];
    logic [47:0] macc;
    logic [47:0] last_s;
    logic [3:0]  last_c;
    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          lat_chk = 1'b1;
    bit          rnd_ready = 1'b0;
    bit          accepted;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_push();
        exp_t        e;
        logic [47:0] s;
        logic [3:0]  cc;
        for (int k = 0; k < 4; k++) begin
            logic [11:0] wl, xl, yl, zs, t, t2, sel;
            logic [12:0] full;
            xl   = X[k*12 +: 12];
            yl   = Y[k*12 +: 12];
            wl   = acc_clr ? 12'h000 : (acc_en ? macc[k*12 +: 12] : W[k*12 +: 12]);
            zs   = Z[k*12 +: 12] ^ (z_inv ? 12'hFFF : 12'h000);
            t    = 12'(wl + xl + yl + 12'(cin[k]));
            t2   = t ^ (wxy_inv ? 12'hFFF : 12'h000);
            full = {1'b0, t2} + {1'b0, zs} + 13'(z_inv);
            case (op)
                2'b00:   sel = full[11:0];
                2'b01:   sel = xl ^ zs ^ yl;
                2'b10:   sel = xl & zs;
                default: sel = xl | zs;
            endcase
            s[k*12 +: 12] = sel ^ (s_inv ? 12'hFFF : 12'h000);
            cc[k] = (op == 2'b00) ? full[12] : 1'b0;
        end
        if (acc_en || acc_clr) macc = s;
        e.s = s;
        e.c = cc;
        e.cyc = cyc;
        sb.push_back(e);
    endfunction

    // Observe both handshakes at the falling edge, then advance one clock.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        accepted = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 64'(out_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("S", 64'(S), 64'(e.s));
                chk("cout", 64'(cout), 64'(e.c));
                if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'(2));
                last_s = S;
                last_c = cout;
                outs.push_back(S);
            end
        end
        if (accepted) model_push();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic beat(input logic [47:0] w, x, y, z, input logic [1:0] o,
                        input logic zi, wi, si, input logic [3:0] ci,
                        input logic ae, ac);
        int n;
        W = w; X = x; Y = y; Z = z; op = o;
        z_inv = zi; wxy_inv = wi; s_inv = si; cin = ci;
        acc_en = ae; acc_clr = ac;
        in_valid = 1'b1;
        n = 0;
        accepted = 1'b0;
        while (!accepted && n < 50) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        if (!accepted) chk("accept_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'(0));
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        W = '0; X = '0; Y = '0; Z = '0; op = '0;
        z_inv = 0; wxy_inv = 0; s_inv = 0; cin = '0; acc_en = 0; acc_clr = 0;
        macc = '0; last_s = '0; last_c = '0;
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_S", 64'(S), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        // Lane-isolated carry-in.
        beat(48'h0, 48'h0, 48'h0, 48'h000_FFF_001_7FF, 2'b00, 0, 0, 0, 4'b0001, 0, 0);
        drain();
        chk("lane_cin_S", 64'(last_s), 64'h0000_0000_FFF0_0180 << 4);
        chk("lane_cin_cout", 64'(last_c), 64'(0));

        // Subtraction through z_inv.
        beat(48'h0, 48'h005, 48'h0, 48'h003, 2'b00, 1, 0, 0, 4'b0000, 0, 0);
        drain();
        chk("sub_lane0", 64'(last_s[11:0]), 64'h002);
        chk("sub_cout0", 64'(last_c[0]), 64'(1));

        // Back-to-back accumulation.
        outs.delete();
        beat(48'h0, 48'h001_001_001_001, 48'h0, 48'h0, 2'b00, 0, 0, 0, 4'b0, 0, 1);
        for (int i = 0; i < 3; i++)
            beat(48'h0, 48'h001_001_001_001, 48'h0, 48'h0, 2'b00, 0, 0, 0, 4'b0, 1, 0);
        drain();
        chk("acc_count", 64'(outs.size()), 64'(4));
        if (outs.size() == 4) begin
            chk("acc_1", 64'(outs[0]), 64'h001_001_001_001);
            chk("acc_2", 64'(outs[1]), 64'h002_002_002_002);
            chk("acc_3", 64'(outs[2]), 64'h003_003_003_003);
            chk("acc_4", 64'(outs[3]), 64'h004_004_004_004);
        end

        // Backpressure: two beats fill the pipe, first result held.
        lat_chk = 1'b0;
        out_ready = 1'b0;
        outs.delete();
        beat(48'h0, 48'h123_456_789_ABC, 48'h0, 48'h111_111_111_111, 2'b00, 0, 0, 0, 4'b0, 0, 0);
        beat(48'h0, 48'hFED_CBA_987_654, 48'h0, 48'h222_222_222_222, 2'b01, 0, 0, 0, 4'b0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", 64'(in_ready), 64'(0));
            chk("stall_out_valid", 64'(out_valid), 64'(1));
            chk("stall_S_hold", 64'(S), 64'(sb[0].s));
            tick();
        end
        drain();
        chk("stall_count", 64'(outs.size()), 64'(2));
        lat_chk = 1'b1;

        // Logical AND with result inversion.
        beat(48'h0, 48'hFFF_FFF_FFF_FFF, 48'h0, 48'h0F0_F0F_0F0_F0F, 2'b10, 0, 0, 1, 4'b1111, 0, 0);
        drain();
        chk("nand_S", 64'(last_s), 64'hF0F_0F0_F0F_0F0);
        chk("nand_cout", 64'(last_c), 64'(0));

        // Partial inversion and all-ones carry-out.
        beat(48'h800_000_FFF_001, 48'h7FF_000_000_002, 48'h001_000_000_003, 48'hFFF_FFF_001_004,
             2'b00, 0, 1, 0, 4'b1010, 0, 0);
        drain();

        // Randomised beats with random consumer stalls.
        lat_chk = 1'b0;
        rnd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            beat(48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}),
                 48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
        end
        rnd_ready = 1'b0;
        drain();
        lat_chk = 1'b1;

        // Reset with two accumulating beats in flight.
        out_ready = 1'b1;
        beat(48'h0, 48'h005_005_005_005, 48'h0, 48'h0, 2'b00, 0, 0, 0, 4'b0, 1, 0);
        beat(48'h0, 48'h005_005_005_005, 48'h0, 48'h0, 2'b00, 0, 0, 0, 4'b0, 1, 0);
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_S", 64'(S), 64'(0));
        chk("midrst_cout", 64'(cout), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        sb.delete();
        macc = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("postrst_no_stale", 64'(out_valid), 64'(0));
        end
        chk("postrst_in_ready", 64'(in_ready), 64'(1));
        beat(48'h0, 48'h0, 48'h0, 48'h0, 2'b00, 0, 0, 0, 4'b0, 1, 0);
        drain();
        chk("postrst_acc_zero", 64'(last_s), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
